// File: rtl/sd_irq_pkg.sv
// Shared definitions for the SD interrupt aggregator: register map and FSM encoding.
package sd_irq_pkg;

  localparam logic [2:0] REG_NSTAT = 3'd0;
  localparam logic [2:0] REG_ESTAT = 3'd1;
  localparam logic [2:0] REG_BSTAT = 3'd2;
  localparam logic [2:0] REG_NEN   = 3'd3;
  localparam logic [2:0] REG_EEN   = 3'd4;
  localparam logic [2:0] REG_BEN   = 3'd5;
  localparam logic [2:0] REG_COAL  = 3'd6;
  localparam logic [2:0] REG_CNT   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_FIRE   = 2'd2
  } coal_state_e;

endpackage

// File: rtl/sd_irq_ctrl_if.sv
// Register-window bus between the SD top's slave decode and the interrupt aggregator.
interface sd_irq_ctrl_if;
  logic [2:0]  reg_sel_i;
  logic        reg_we_i;
  logic        reg_re_i;
  logic [31:0] reg_wdat_i;
  logic [31:0] reg_rdat_o;

  modport master (output reg_sel_i, reg_we_i, reg_re_i, reg_wdat_i, input reg_rdat_o);
  modport slave  (input reg_sel_i, reg_we_i, reg_re_i, reg_wdat_i, output reg_rdat_o);
endinterface

// File: rtl/sd_edge_sticky.sv
// Rising-edge detector feeding a sticky write-1-to-clear status register.
module sd_edge_sticky #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] evt,
  input  logic [W-1:0] clr,
  output logic [W-1:0] rise,
  output logic [W-1:0] stat
);

  logic [W-1:0] evt_q;

  assign rise = evt & ~evt_q;

  // Edge history follows the input even in reset, so levels already high at
  // reset release are not mistaken for new edges.
  always_ff @(posedge clk) begin
    evt_q <= evt;
  end

  // Sticky status: a new rise wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) stat <= '0;
    else        stat <= (stat & ~clr) | rise;
  end

endmodule

// File: rtl/sd_irq_ctrl.sv
// Interrupt aggregator: sticky status, enables, event coalescing and the register window.
module sd_irq_ctrl
  import sd_irq_pkg::*;
#(
  parameter int NORM_W     = 16,
  parameter int ERR_W      = 16,
  parameter int BD_W       = 8,
  parameter int COAL_CNT_W = 8,
  parameter int COAL_TMR_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [NORM_W-1:0] norm_evt_i,
  input  logic [ERR_W-1:0]  err_evt_i,
  input  logic [BD_W-1:0]   bd_evt_i,
  sd_irq_ctrl_if.slave      bus,
  output logic              int_a,
  output logic              int_b,
  output logic              int_c,
  output logic              irq_o
);

  logic [NORM_W-2:0] nstat_raw, rise_n, clr_n;
  logic [ERR_W-1:0]  estat, rise_e, clr_e;
  logic [BD_W-1:0]   bstat, rise_b, clr_b;
  logic [NORM_W-1:0] nstat, nen;
  logic [ERR_W-1:0]  een;
  logic [BD_W-1:0]   ben;
  logic [COAL_CNT_W-1:0] coal_cnt, cnt_q, cnt_inc;
  logic [COAL_TMR_W-1:0] coal_tmr, tmr_q, tmr_inc;
  coal_state_e state;
  logic ev, any_int, bypass, hit;
  logic [31:0] rd_mux;

  // The top normal bit is the error summary, so its event input has no use.
  logic unused_ok;
  assign unused_ok = ^{norm_evt_i[NORM_W-1], rise_e};

  assign clr_n = (bus.reg_we_i && bus.reg_sel_i == REG_NSTAT) ? bus.reg_wdat_i[NORM_W-2:0] : '0;
  assign clr_e = (bus.reg_we_i && bus.reg_sel_i == REG_ESTAT) ? bus.reg_wdat_i[ERR_W-1:0]  : '0;
  assign clr_b = (bus.reg_we_i && bus.reg_sel_i == REG_BSTAT) ? bus.reg_wdat_i[BD_W-1:0]   : '0;

  sd_edge_sticky #(.W(NORM_W-1)) u_norm (.clk(wb_clk_i), .rst_n(wb_rst_n_i),
    .evt(norm_evt_i[NORM_W-2:0]), .clr(clr_n), .rise(rise_n), .stat(nstat_raw));
  sd_edge_sticky #(.W(ERR_W)) u_err (.clk(wb_clk_i), .rst_n(wb_rst_n_i),
    .evt(err_evt_i), .clr(clr_e), .rise(rise_e), .stat(estat));
  sd_edge_sticky #(.W(BD_W)) u_bd (.clk(wb_clk_i), .rst_n(wb_rst_n_i),
    .evt(bd_evt_i), .clr(clr_b), .rise(rise_b), .stat(bstat));

  assign nstat   = {|estat, nstat_raw};
  assign int_a   = |(nstat & nen);
  assign int_b   = |(estat & een);
  assign int_c   = |(bstat & ben);
  assign any_int = int_a | int_b | int_c;

  // Coalescing: errors never wait, and an all-zero COAL passes everything through.
  assign ev      = (|(rise_n & nen[NORM_W-2:0])) | (|(rise_b & ben));
  assign bypass  = (coal_cnt == '0) && (coal_tmr == '0);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + COAL_CNT_W'(ev);
  assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + COAL_TMR_W'(1);
  assign hit     = ((coal_cnt != '0) && (cnt_inc >= coal_cnt)) ||
                   ((coal_tmr != '0) && (tmr_inc >= coal_tmr));
  assign irq_o   = int_b | (state == ST_FIRE) | (bypass & any_int);

  // Enable and coalescing configuration registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      nen <= '0; een <= '0; ben <= '0; coal_cnt <= '0; coal_tmr <= '0;
    end else if (bus.reg_we_i) begin
      case (bus.reg_sel_i)
        REG_NEN:  nen <= bus.reg_wdat_i[NORM_W-1:0];
        REG_EEN:  een <= bus.reg_wdat_i[ERR_W-1:0];
        REG_BEN:  ben <= bus.reg_wdat_i[BD_W-1:0];
        REG_COAL: begin
          coal_cnt <= bus.reg_wdat_i[COAL_CNT_W-1:0];
          coal_tmr <= bus.reg_wdat_i[16 +: COAL_TMR_W];
        end
        default: ;
      endcase
    end
  end

  // Coalescing FSM; thresholds compare against the post-update count/timer.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i || bypass) begin
      state <= ST_IDLE; cnt_q <= '0; tmr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (ev) begin
          state <= ST_GATHER; cnt_q <= COAL_CNT_W'(1); tmr_q <= '0;
        end
        ST_GATHER: if (!any_int && !ev) begin
          state <= ST_IDLE; cnt_q <= '0; tmr_q <= '0;
        end else begin
          cnt_q <= cnt_inc;
          tmr_q <= tmr_inc;
          if (hit) state <= ST_FIRE;
        end
        ST_FIRE: if (!any_int) begin
          state <= ST_IDLE; cnt_q <= '0; tmr_q <= '0;
        end
        default: begin
          state <= ST_IDLE; cnt_q <= '0; tmr_q <= '0;
        end
      endcase
    end
  end

  // Read mux sees pre-write values, so a same-cycle read/write returns the old contents.
  always_comb begin
    rd_mux = '0;
    case (bus.reg_sel_i)
      REG_NSTAT: rd_mux[NORM_W-1:0] = nstat;
      REG_ESTAT: rd_mux[ERR_W-1:0]  = estat;
      REG_BSTAT: rd_mux[BD_W-1:0]   = bstat;
      REG_NEN:   rd_mux[NORM_W-1:0] = nen;
      REG_EEN:   rd_mux[ERR_W-1:0]  = een;
      REG_BEN:   rd_mux[BD_W-1:0]   = ben;
      REG_COAL: begin
        rd_mux[COAL_CNT_W-1:0]   = coal_cnt;
        rd_mux[16 +: COAL_TMR_W] = coal_tmr;
      end
      REG_CNT: begin
        rd_mux[COAL_CNT_W-1:0]   = cnt_q;
        rd_mux[16 +: COAL_TMR_W] = tmr_q;
      end
      default: ;
    endcase
  end

  // Registered read data, one cycle after the read strobe.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i)         bus.reg_rdat_o <= '0;
    else if (bus.reg_re_i)   bus.reg_rdat_o <= rd_mux;
  end

endmodule

// File: tb/tb_sd_irq_ctrl.sv
// Directed self-checking bench for sd_irq_ctrl.
module tb_sd_irq_ctrl;
  import sd_irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] norm_evt;
  logic [15:0] err_evt;
  logic [7:0]  bd_evt;
  logic        int_a, int_b, int_c, irq;
  logic [31:0] d;
  logic        early;
  int          checks = 0;
  int          errors = 0;

  sd_irq_ctrl_if bus ();

  sd_irq_ctrl dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .norm_evt_i(norm_evt), .err_evt_i(err_evt), .bd_evt_i(bd_evt),
    .bus(bus),
    .int_a(int_a), .int_b(int_b), .int_c(int_c), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    bus.reg_sel_i = sel; bus.reg_wdat_i = data; bus.reg_we_i = 1'b1;
    tick();
    bus.reg_we_i = 1'b0;
    $display("WR sel=%0d data=%h", sel, data);
  endtask

  task automatic rd(input logic [2:0] sel, output logic [31:0] data);
    bus.reg_sel_i = sel; bus.reg_re_i = 1'b1;
    tick();
    bus.reg_re_i = 1'b0;
    data = bus.reg_rdat_o;
    $display("RD sel=%0d data=%h", sel, data);
  endtask

  initial begin
    rst_n = 1'b0;
    norm_evt = 16'hFFFF; err_evt = 16'hFFFF; bd_evt = 8'hFF;
    bus.reg_sel_i = '0; bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0; bus.reg_wdat_i = '0;

    // Reset with all events high; a read in reset must return zero
    tick(); tick();
    rd(REG_NSTAT, d);
    chk("rst_rdat", d, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_int_a", {31'b0, int_a}, 32'h0);

    // Release with events held high: no rise, status stays clear
    rst_n = 1'b1;
    tick(); tick();
    rd(REG_NSTAT, d); chk("post_rst_nstat", d, 32'h0);
    rd(REG_ESTAT, d); chk("post_rst_estat", d, 32'h0);
    rd(REG_BSTAT, d); chk("post_rst_bstat", d, 32'h0);
    norm_evt = '0; err_evt = '0; bd_evt = '0;
    tick();

    // Edge latch and W1C (COAL=0, bypass)
    wr(REG_NEN, 32'h0000_FFFF);
    norm_evt = 16'h0001;
    tick();
    chk("edge_int_a", {31'b0, int_a}, 32'h1);
    chk("edge_irq_bypass", {31'b0, irq}, 32'h1);
    rd(REG_NSTAT, d); chk("edge_nstat", d, 32'h0000_0001);
    wr(REG_NSTAT, 32'h0000_0001);
    chk("w1c_int_a", {31'b0, int_a}, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    norm_evt = '0;
    tick();

    // Set beats clear on the same bit
    bus.reg_sel_i = REG_NSTAT; bus.reg_wdat_i = 32'h8; bus.reg_we_i = 1'b1;
    norm_evt = 16'h0008;
    tick();
    bus.reg_we_i = 1'b0;
    rd(REG_NSTAT, d); chk("set_beats_clr", d, 32'h0000_0008);
    wr(REG_NSTAT, 32'h8);
    rd(REG_NSTAT, d); chk("clr_bit3", d, 32'h0);
    norm_evt = '0;
    tick();

    // Count coalescing, threshold 4
    wr(REG_COAL, 32'h0000_0004);
    norm_evt = 16'h0001; tick();
    chk("cnt_rise1_irq", {31'b0, irq}, 32'h0);
    norm_evt = 16'h0003; tick();
    norm_evt = 16'h0007; tick();
    chk("cnt_rise3_irq", {31'b0, irq}, 32'h0);
    norm_evt = 16'h000F; tick();
    chk("cnt_rise4_irq", {31'b0, irq}, 32'h1);
    rd(REG_CNT, d); chk("cnt_fire_cnt", d, 32'h0003_0004);
    wr(REG_NSTAT, 32'h0000_FFFF);
    tick();
    chk("cnt_w1c_irq", {31'b0, irq}, 32'h0);
    rd(REG_CNT, d); chk("cnt_cleared", d, 32'h0);
    norm_evt = '0;
    tick();

    // Timer coalescing, timeout 100: fires exactly 101 cycles after the rise cycle
    wr(REG_COAL, 32'h0064_0000);
    norm_evt = 16'h0001;
    tick();
    early = irq;
    repeat (99) begin
      tick();
      if (irq) early = 1'b1;
    end
    chk("tmr_not_early", {31'b0, early}, 32'h0);
    tick();
    chk("tmr_fire", {31'b0, irq}, 32'h1);
    wr(REG_NSTAT, 32'h0000_FFFF);
    tick();
    chk("tmr_w1c_irq", {31'b0, irq}, 32'h0);
    norm_evt = '0;
    tick();

    // Error bypass and NSTAT summary bit
    wr(REG_COAL, 32'h0000_0008);
    wr(REG_EEN, 32'h0000_0002);
    err_evt = 16'h0002;
    tick();
    chk("err_int_b", {31'b0, int_b}, 32'h1);
    chk("err_irq", {31'b0, irq}, 32'h1);
    chk("err_summary_int_a", {31'b0, int_a}, 32'h1);
    rd(REG_NSTAT, d); chk("err_nstat_summary", d, 32'h0000_8000);
    rd(REG_ESTAT, d); chk("err_estat", d, 32'h0000_0002);
    wr(REG_ESTAT, 32'h0000_0002);
    chk("err_clr_int_b", {31'b0, int_b}, 32'h0);
    chk("err_clr_irq", {31'b0, irq}, 32'h0);
    err_evt = '0;
    tick();

    // BD event gathered then cleared: back to IDLE without an irq
    wr(REG_BEN, 32'h0000_0001);
    bd_evt = 8'h01;
    tick();
    chk("bd_int_c", {31'b0, int_c}, 32'h1);
    chk("bd_gather_irq", {31'b0, irq}, 32'h0);
    wr(REG_BSTAT, 32'h0000_0001);
    chk("bd_clr_int_c", {31'b0, int_c}, 32'h0);
    tick();
    rd(REG_CNT, d); chk("bd_gather_abort_cnt", d, 32'h0);
    chk("bd_abort_irq", {31'b0, irq}, 32'h0);
    bd_evt = '0;
    tick();

    // Simultaneous read and write returns the pre-write value
    bus.reg_sel_i = REG_NEN; bus.reg_wdat_i = 32'h0000_1234;
    bus.reg_we_i = 1'b1; bus.reg_re_i = 1'b1;
    tick();
    bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0;
    chk("rw_same_old", bus.reg_rdat_o, 32'h0000_FFFF);
    rd(REG_NEN, d); chk("rw_same_new", d, 32'h0000_1234);
    rd(REG_COAL, d); chk("coal_readback", d, 32'h0000_0008);

    // Reset wins over a simultaneous write
    rst_n = 1'b0;
    wr(REG_NEN, 32'h0000_ABCD);
    rst_n = 1'b1;
    rd(REG_NEN, d); chk("rst_beats_wr", d, 32'h0);
    chk("final_irq", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
